// File: rtl/sa_operand_loader_if.sv
// Byte-stream input and SRAM write port of one operand-bank loader.
// Handshake: a byte moves on a rising clk edge where s_valid && s_ready; s_data is held while s_valid waits.
interface sa_operand_loader_if #(
  parameter int N  = 8,
  parameter int AW = 13
);
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          wen_n;
  logic [AW-1:0] waddr;
  logic [N*8-1:0] wdata;

  modport master (output s_valid, s_data, input s_ready, wen_n, waddr, wdata);
  modport slave  (input s_valid, s_data, output s_ready, wen_n, waddr, wdata);
endinterface

// File: rtl/sa_operand_loader.sv
// Packs a host byte stream into N-byte words and writes them, tile by tile,
// into one operand SRAM bank starting at a latched base address.
module sa_operand_loader #(
  parameter int N  = 8,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [7:0]    k_param,
  input  logic [7:0]    tile_cnt,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state,
  sa_operand_loader_if.slave bus
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [LW-1:0]  lane_q;
  logic [N*8-1:0] pack_q, pack_d;
  logic [N*8-1:0] wdata_q;
  logic [AW-1:0]  waddr_q, addr_w, prod_w;
  logic           wen_n_q;
  logic [AW-1:0]  base_q;
  logic [7:0]     kp_q, tc_q, k_q, t_q;
  logic           accept, lane_last, last_word, start_ok;

  assign start_ok  = start && (state_q == S_IDLE);
  assign accept    = bus.s_valid && (state_q == S_LOAD);
  assign lane_last = (lane_q == LW'(N - 1));
  assign last_word = (t_q == tc_q - 8'd1) && (k_q == kp_q - 8'd1);

  // Address arithmetic is modulo 2^AW, so it can be carried at AW bits directly.
  assign prod_w = AW'({8'd0, t_q} * {8'd0, kp_q});
  assign addr_w = base_q + prod_w + AW'(k_q);

  always_comb begin
    pack_d = pack_q;
    if (accept) pack_d[int'(lane_q)*8 +: 8] = bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FLUSH covers the cycle the final write is on the bus; DONE carries the pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (k_param == 8'd0 || tile_cnt == 8'd0) ? S_FLUSH : S_LOAD;
      S_LOAD:  if (accept && lane_last && last_word) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready = (state_q == S_LOAD);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    dbg_state   = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      pack_q  <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      wen_n_q <= 1'b1;
      base_q  <= '0;
      kp_q    <= '0;
      tc_q    <= '0;
      k_q     <= '0;
      t_q     <= '0;
    end else begin
      wen_n_q <= 1'b1;
      if (start_ok) begin
        base_q <= base_addr;
        kp_q   <= k_param;
        tc_q   <= tile_cnt;
        k_q    <= '0;
        t_q    <= '0;
        lane_q <= '0;
      end
      if (accept) begin
        pack_q <= pack_d;
        if (lane_last) begin
          lane_q  <= '0;
          wen_n_q <= 1'b0;
          waddr_q <= addr_w;
          wdata_q <= pack_d;
          if (k_q == kp_q - 8'd1) begin
            k_q <= '0;
            t_q <= t_q + 8'd1;
          end else begin
            k_q <= k_q + 8'd1;
          end
        end else begin
          lane_q <= lane_q + LW'(1);
        end
      end
    end
  end

  assign bus.wen_n = wen_n_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_sa_operand_loader.sv
// Directed and randomized jobs for sa_operand_loader, checked against a
// word-list model built from the byte stream and the address formula.
module tb_sa_operand_loader;
  localparam int N  = 8;
  localparam int AW = 13;
  localparam int W  = AW + N*8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [7:0]    k_param, tile_cnt;
  logic          busy, done;
  logic [1:0]    dbg_state;

  sa_operand_loader_if #(.N(N), .AW(AW)) bus();

  sa_operand_loader #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .k_param   (k_param),
    .tile_cnt  (tile_cnt),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, wr_in_job = 0, exp_gap = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [7:0]   stream[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Write monitor: every SRAM write must match the head of the expected queue.
  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1 && bus.wen_n === 1'b0) begin
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("waddr", 64'(bus.waddr), 64'(mon_e[W-1:N*8]));
        check("wdata", 64'(bus.wdata), 64'(mon_e[N*8-1:0]));
      end
      if (exp_gap != 0 && wr_in_job > 0) check("wr_gap", 64'(cyc - last_wr_cyc), 64'(exp_gap));
      wr_in_job++;
      last_wr_cyc = cyc;
    end
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference model: word w is bytes 8w..8w+7 little-lane-first, at base + t*k + kk mod 2^AW.
  function automatic logic [AW-1:0] model_jobs(input int base, input int k, input int tiles);
    logic [AW-1:0] a;
    logic [63:0]   d;
    a = '0;
    for (int w = 0; w < k*tiles; w++) begin
      a = AW'((base + (w / k) * k + (w % k)) % (1 << AW));
      d = '0;
      for (int j = 0; j < N; j++) d = d | (64'(stream[w*N + j]) << (8*j));
      exp_q.push_back({a, d});
    end
    return a;
  endfunction

  task automatic pulse_start(input int base, input int k, input int tiles);
    base_addr = AW'(base);
    k_param   = 8'(k);
    tile_cnt  = 8'(tiles);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    k_param   = 8'($urandom);
    tile_cnt  = 8'($urandom);
  endtask

  // mode 0: continuous, 1: valid toggles 1/0, 2: random valid
  task automatic run_job(input int base, input int k, input int tiles, input int mode,
                         input bit seq, input int restart_idx);
    int total, idx, budget, d0;
    bit tog, acc, restarted;
    logic [AW-1:0] last_addr;
    total = k * tiles * N;
    stream.delete();
    for (int i = 0; i < total; i++) stream.push_back(seq ? 8'(i) : 8'($urandom));
    last_addr = model_jobs(base, k, tiles);
    exp_gap   = (mode == 0) ? N : (mode == 1) ? 2*N : 0;
    wr_in_job = 0;
    d0 = done_cnt;
    pulse_start(base, k, tiles);
    idx = 0; budget = 0; tog = 1'b1; restarted = 1'b0;
    while (idx < total && budget < 4000) begin
      bus.s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      bus.s_data  = stream[idx];
      if (idx == restart_idx && !restarted) begin
        start = 1'b1;
        base_addr = 13'h0AAA;
        restarted = 1'b1;
      end
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      start = 1'b0;
      tog = !tog;
      budget++;
    end
    bus.s_valid = 1'b0;
    check("bytes_accepted", 64'(idx), 64'(total));
    check("ready_after_last", 64'(bus.s_ready), 64'd0);
    check("busy_after_last", 64'(busy), 64'd1);
    budget = 0;
    while (done_cnt == d0 && budget < 10) begin
      @(negedge clk); #1;
      budget++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'd1);
    check("done_after_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
    @(negedge clk); #1;
    check("busy_fall", 64'(busy), 64'd0);
    check("single_done", 64'(done_cnt - d0), 64'd1);
    check("writes_missing", 64'(exp_q.size()), 64'd0);
    check("waddr_hold", 64'(bus.waddr), 64'(last_addr));
  endtask

  task automatic run_empty(input int k, input int tiles);
    int d0;
    d0 = done_cnt;
    wr_in_job = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'($urandom);
    pulse_start(16'h0123, k, tiles);
    @(negedge clk);
    check("empty_done_c1", 64'(done), 64'd0);
    check("empty_ready_c1", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    check("empty_done_c2", 64'(done), 64'd1);
    check("empty_ready_c2", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    check("empty_done_c3", 64'(done), 64'd0);
    check("empty_busy_c3", 64'(busy), 64'd0);
    #1;
    check("empty_done_cnt", 64'(done_cnt - d0), 64'd1);
    bus.s_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.s_ready), 64'd0);
    check({tag, "_wen_n"}, 64'(bus.wen_n), 64'd1);
    check({tag, "_waddr"}, 64'(bus.waddr), 64'd0);
    check({tag, "_wdata"}, 64'(bus.wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    int d0, idx;
    bit acc;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; k_param = '0; tile_cnt = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    run_job(16'h100, 2, 3, 0, 1'b1, -1);   // continuous, data 0..47
    run_job(16'h100, 2, 3, 1, 1'b1, -1);   // toggling valid
    run_job(16'h1FFE, 4, 1, 0, 1'b0, -1);  // address wrap
    run_empty(0, 5);
    run_empty(3, 0);
    run_job(16'h0200, 3, 2, 0, 1'b0, 20);  // start re-pulsed mid-load

    // Reset after 3 bytes of word 1: only word 0 may reach the SRAM.
    stream.delete();
    for (int i = 0; i < 2*N; i++) stream.push_back(8'($urandom));
    void'(model_jobs(16'h0040, 2, 1));
    void'(exp_q.pop_back());
    exp_gap = 0;
    d0 = done_cnt;
    pulse_start(16'h0040, 2, 1);
    idx = 0;
    while (idx < N + 3 && cyc < 90000) begin
      bus.s_valid = 1'b1;
      bus.s_data  = stream[idx];
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    #1;
    check("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    check("midreset_word0", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(16'h0040, 2, 1, 0, 1'b0, -1);  // clean reload from lane 0

    for (int r = 0; r < 4; r++)
      run_job(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(1, 4)),
              int'($urandom_range(1, 3)), 2, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
